// File: rtl/rv_pkg.sv
// Shared RV32I load/store encodings, FSM state type and access-size decode.
// Latency: n/a (types, constants, pure function).
// Backpressure: n/a.
package rv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    // Request context latched when a transaction is accepted
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
    } cap_t;

    // Access size from funct3; any encoding not listed is a word access
    function automatic size_t acc_size(input logic [2:0] f3, input logic is_store);
        size_t sz;
        sz = SZ_WORD;
        if (is_store) begin
            if (f3 == F3_SB)      sz = SZ_BYTE;
            else if (f3 == F3_SH) sz = SZ_HALF;
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_BYTE;
            else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
        end
        return sz;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the load lane from a bus word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module load_align
    import rv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [15:0] lane;
    logic        sgn;

    // Shift the addressed lane down to bit 0, then extend by size/sign
    always_comb begin
        lane = 16'(rdata >> {offset, 3'b000});
        sgn  = ~funct3[2];
        data = rdata;
        case (acc_size(funct3, 1'b0))
            SZ_BYTE: data = {{24{sgn & lane[7]}}, lane[7:0]};
            SZ_HALF: data = {{16{sgn & lane[15]}}, lane[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: MEM-stage load/store to a req/ack bus, lane placement and load alignment.
// Latency: stall 2 cycles with ack in first REQ cycle, +1 per wait cycle; load_valid the cycle after ack.
// Backpressure: stall holds the pipeline until ack; DMEM_MISALIGN_TRAP_EN traps misaligned accesses instead of truncating.
module dmem_ctrl
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_mem_read,
    input  logic        en_mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] rdata2,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t      state, state_nxt;
    cap_t        cap;
    size_t       sz;
    logic        req_in;
    logic        trap;
    logic        accept;
    logic [1:0]  off;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] aligned;

    // Request qualified by reset so no output can assert while held in reset
    assign req_in = rst & (en_mem_read | en_mem_write);

    // Size, naturally-aligned lane offset and store lane placement
    always_comb begin
        sz        = acc_size(funct3, en_mem_write);
        off       = 2'b00;
        be_nxt    = 4'b1111;
        wdata_nxt = rdata2;
        case (sz)
            SZ_BYTE: begin
                off       = addr[1:0];
                be_nxt    = 4'b0001 << off;
                wdata_nxt = {4{rdata2[7:0]}};
            end
            SZ_HALF: begin
                off       = {addr[1], 1'b0};
                be_nxt    = 4'b0011 << off;
                wdata_nxt = {2{rdata2[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis;
    assign mis  = ((sz == SZ_HALF) && addr[0]) || ((sz == SZ_WORD) && (addr[1:0] != 2'b00));
    assign trap = (state == ST_IDLE) & req_in & mis;
`else
    assign trap = 1'b0;
`endif

    assign misalign = trap;
    assign accept   = req_in & ~trap;

    load_align u_load_align (
        .rdata  (bus_rdata),
        .offset (cap.off),
        .funct3 (cap.funct3),
        .data   (aligned)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Capture request on acceptance; capture aligned load data on ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap       <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            load_data <= '0;
        end else begin
            if (state == ST_IDLE && accept) begin
                cap.we     <= en_mem_write;
                cap.funct3 <= funct3;
                cap.off    <= off;
                bus_addr   <= {addr[31:2], 2'b00};
                bus_wdata  <= wdata_nxt;
                bus_be     <= be_nxt;
            end
            if (state == ST_REQ && bus_ack && !cap.we)
                load_data <= aligned;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        load_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                bus_we  = cap.we;
                if (bus_ack) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                load_valid = ~cap.we;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_mem_read, en_mem_write;
    logic [31:0] addr, rdata2;
    logic [2:0]  funct3;
    logic        stall, load_valid, misalign, bus_req, bus_we, bus_ack;
    logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int K_BUS  = 0;
    localparam int K_LOAD = 1;
    localparam int K_MIS  = 2;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en_mem_read  (en_mem_read),
        .en_mem_write (en_mem_write),
        .addr         (addr),
        .rdata2       (rdata2),
        .funct3       (funct3),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign     (misalign),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        e = '{kind: K_BUS, we: we, addr: a, wdata: wd, be: be, data: 32'h0};
        sb.push_back(e);
    endtask

    task automatic push_load(input logic [31:0] d);
        exp_t e;
        e = '{kind: K_LOAD, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0, data: d};
        sb.push_back(e);
    endtask

    task automatic push_mis();
        exp_t e;
        e = '{kind: K_MIS, we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0, data: 32'h0};
        sb.push_back(e);
    endtask

    // Pipeline model: request held while stall is high; ack after 'waits' REQ cycles
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                             input int waits, input logic [31:0] rdat, input int exp_stall);
        int   sc;
        int   rc;
        logic done;
        sc   = 0;
        rc   = 0;
        done = 1'b0;
        @(posedge clk); #1;
        en_mem_read  = rd;
        en_mem_write = wr;
        addr         = a;
        rdata2       = d;
        funct3       = f3;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) sc++;
            if (bus_req) begin
                if (rc == waits) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdat;
                end
                rc++;
            end
            if (!stall) done = 1'b1;
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        en_mem_read  = 1'b0;
        en_mem_write = 1'b0;
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_stall_cycles"}, sc, exp_stall);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin : monitor
        exp_t e;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev_req) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_bus_req: got addr %h expected no request", bus_addr);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_bus", K_BUS, e.kind);
                    check("bus_addr", bus_addr, e.addr);
                    check("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                    if (e.we) begin
                        check("bus_be", {28'd0, bus_be}, {28'd0, e.be});
                        check("bus_wdata", bus_wdata, e.wdata);
                    end
                end
            end
            if (load_valid) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_load_valid: got data %h expected no pulse", load_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_load", K_LOAD, e.kind);
                    check("load_data", load_data, e.data);
                end
            end
            if (misalign) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_misalign: got 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_mis", K_MIS, e.kind);
                    check("mis_no_bus", {31'd0, bus_req}, 32'd0);
                end
            end
            prev_req = bus_req;
        end
    end

    initial begin : stim
        rst          = 1'b0;
        en_mem_read  = 1'b0;
        en_mem_write = 1'b0;
        addr         = '0;
        rdata2       = '0;
        funct3       = '0;
        bus_ack      = 1'b0;
        bus_rdata    = '0;

        repeat (2) @(negedge clk);
        check("rst_stall",      {31'd0, stall},      32'd0);
        check("rst_bus_req",    {31'd0, bus_req},    32'd0);
        check("rst_bus_we",     {31'd0, bus_we},     32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_misalign",   {31'd0, misalign},   32'd0);
        check("rst_bus_addr",   bus_addr,            32'd0);
        check("rst_bus_wdata",  bus_wdata,           32'd0);
        check("rst_bus_be",     {28'd0, bus_be},     32'd0);
        check("rst_load_data",  load_data,           32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // SW, ack in third REQ cycle
        push_bus(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
        do_access("sw", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, F3_SW, 2, 32'h0, 4);

        // LB from top lane, negative byte
        push_bus(1'b0, 32'h200, 32'h0, 4'h0);
        push_load(32'hFFFFFF80);
        do_access("lb", 1'b1, 1'b0, 32'h203, 32'h0, F3_LB, 0, 32'h80FFFF7F, 2);

        // SH upper half
        push_bus(1'b1, 32'h100, 32'h12341234, 4'b1100);
        do_access("sh", 1'b0, 1'b1, 32'h102, 32'h00001234, F3_SH, 0, 32'h0, 2);

        // Read and write together behave as a store
        push_bus(1'b1, 32'h000, 32'hA5A5A5A5, 4'b0010);
        do_access("rw_sb", 1'b1, 1'b1, 32'h001, 32'h000000A5, F3_SB, 0, 32'h0, 2);

        // Misaligned LW
`ifdef DMEM_MISALIGN_TRAP_EN
        push_mis();
        do_access("lw_mis", 1'b1, 1'b0, 32'h101, 32'h0, F3_LW, 0, 32'h11223344, 0);
`else
        push_bus(1'b0, 32'h100, 32'h0, 4'h0);
        push_load(32'h11223344);
        do_access("lw_mis", 1'b1, 1'b0, 32'h101, 32'h0, F3_LW, 0, 32'h11223344, 2);
`endif

        // LBU lane 2, one wait cycle
        push_bus(1'b0, 32'h200, 32'h0, 4'h0);
        push_load(32'h000000FF);
        do_access("lbu", 1'b1, 1'b0, 32'h202, 32'h0, F3_LBU, 1, 32'h80FFFF7F, 3);

        // LH upper half, negative
        push_bus(1'b0, 32'h200, 32'h0, 4'h0);
        push_load(32'hFFFF80FF);
        do_access("lh_hi", 1'b1, 1'b0, 32'h202, 32'h0, F3_LH, 0, 32'h80FFFF7F, 2);

        // LHU lower half
        push_bus(1'b0, 32'h200, 32'h0, 4'h0);
        push_load(32'h0000FF7F);
        do_access("lhu_lo", 1'b1, 1'b0, 32'h200, 32'h0, F3_LHU, 0, 32'h80FFFF7F, 2);

        // LH lower half, negative
        push_bus(1'b0, 32'h200, 32'h0, 4'h0);
        push_load(32'hFFFF8001);
        do_access("lh_lo", 1'b1, 1'b0, 32'h200, 32'h0, F3_LH, 0, 32'h12348001, 2);

        // Undefined funct3 load treated as word
        push_bus(1'b0, 32'h400, 32'h0, 4'h0);
        push_load(32'hCAFEF00D);
        do_access("ld_f3_011", 1'b1, 1'b0, 32'h400, 32'h0, 3'b011, 0, 32'hCAFEF00D, 2);

        // SB top lane; load_data must still hold the last load
        push_bus(1'b1, 32'h100, 32'h78787878, 4'b1000);
        do_access("sb_hi", 1'b0, 1'b1, 32'h103, 32'h12345678, F3_SB, 0, 32'h0, 2);
        check("load_data_hold", load_data, 32'hCAFEF00D);

        // Misaligned SH
`ifdef DMEM_MISALIGN_TRAP_EN
        push_mis();
        do_access("sh_mis", 1'b0, 1'b1, 32'h101, 32'h00001234, F3_SH, 0, 32'h0, 0);
`else
        push_bus(1'b1, 32'h100, 32'h12341234, 4'b0011);
        do_access("sh_mis", 1'b0, 1'b1, 32'h101, 32'h00001234, F3_SH, 0, 32'h0, 2);
`endif

        // Reset during REQ abandons the load; late ack ignored
        push_bus(1'b0, 32'h300, 32'h0, 4'h0);
        @(posedge clk); #1;
        en_mem_read = 1'b1;
        addr        = 32'h300;
        funct3      = F3_LW;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_req_active", {31'd0, bus_req}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_mid_stall",   {31'd0, stall},   32'd0);
        check("rst_mid_bus_addr", bus_addr,        32'd0);
        en_mem_read = 1'b0;
        bus_ack     = 1'b1;
        bus_rdata   = 32'h55667788;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_load_valid", {31'd0, load_valid}, 32'd0);
            check("rst_mid_no_req",        {31'd0, bus_req},    32'd0);
        end
        bus_ack = 1'b0;
        check("rst_mid_load_data", load_data, 32'd0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 en_mem_read  in  1  load request from MEM stage.
REQ-004 en_mem_write  in  1  store request from MEM stage.
REQ-005 addr  in  32  byte address (ALU result).
REQ-006 rdata2  in  32  store data, low-aligned.
REQ-007 funct3  in  3  access size/sign (RV32I load/store encoding).
REQ-008 stall  out  1  holds IF..MEM pipeline registers while high.
REQ-009 load_data  out  32  aligned, extended load result to MEM/WB.
REQ-010 load_valid  out  1  one-cycle pulse, load_data valid.
REQ-011 misalign  out  1  one-cycle pulse, misaligned access (macro-dependent).
REQ-012 bus_req, bus_we  out  1 each  memory request and write-select; held until ack.
REQ-013 bus_addr  out  32  word address, bits [1:0] = 0.
REQ-014 bus_wdata  out  32 / bus_be  out  4  lane-placed store data / byte enables.
REQ-015 bus_ack  in  1 / bus_rdata  in  32  completion; rdata valid with ack on reads.

Function
REQ-016 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-017 IDLE: request (en_mem_read|en_mem_write) captures addr/rdata2/funct3/type, asserts stall combinationally, next state REQ.
REQ-018 Read and write both high: treat as write; read ignored.
REQ-019 REQ: bus_req=1, all bus outputs stable from captured values; stall=1; bus_ack=1 -> DONE, bus_rdata captured on reads.
REQ-020 DONE: stall=0, load_valid=1 for loads only; inputs ignored; next state IDLE.
REQ-021 bus_ack outside REQ ignored.
REQ-022 Minimum timing, ack in first REQ cycle: stall high 2 cycles, load_valid in cycle 3; each extra wait cycle adds one.
REQ-023 Stores: SB (000) be=0001<<addr[1:0], byte replicated x4; SH (001) be=0011<<{addr[1],0}, halfword replicated x2; SW (010) be=1111.
REQ-024 Loads: LB 000 / LH 001 sign-extend, LW 010, LBU 100 / LHU 101 zero-extend, lane chosen by captured addr[1:0].
REQ-025 Other funct3 values: treated as word access.
REQ-026 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-027 load_data holds last load result until next load completes.

Reset
REQ-028 rst low asynchronously forces IDLE; stall, bus_req, bus_we, load_valid, misalign = 0; bus_addr, bus_wdata, bus_be, load_data = 0.
REQ-029 Reset mid-transaction abandons it; no completion pulse after release; late ack ignored.

Configuration
REQ-030 Macro DMEM_MISALIGN_TRAP_EN defined: misaligned request issues no bus access, pulses misalign for its IDLE cycle, no stall, stays IDLE.
REQ-031 Macro undefined: misaligned address truncated to natural alignment and executed normally; misalign tied 0.

Structure
REQ-032 Shared package rv_pkg holds funct3 load/store constants and the FSM state type.
REQ-033 One sub-module load_align: combinational lane select and sign/zero extension.

Verification
REQ-034 SW addr=0x100 data=0xDEADBEEF, ack after 3 cycles -> bus_be=1111, bus_addr=0x100, stall 4 cycles.
REQ-035 LB addr=0x203, bus_rdata=0x80FF_FF7F -> load_data=0xFFFFFF80, load_valid 1 cycle.
REQ-036 SH addr=0x102 data=0x1234 -> bus_be=1100, bus_wdata=0x12341234.
REQ-037 LW addr=0x101: macro on -> misalign pulse, no bus_req; macro off -> bus_addr=0x100.
REQ-038 rst low during REQ, then ack -> bus_req drops immediately, no load_valid.
REQ-039 read+write both high, SB addr=0x001 -> bus_we=1, bus_be=0010.
